// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs 32-bit message beats into 16-word scheduler blocks,
// appends the 0x80 marker, zero fill and the 64-bit bit length, and hands each block to the core.
module sha256_msg_padder (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic [2:0]  in_nbytes,
    input  logic        block_done,
    output logic [31:0] message_word_out,
    output logic [3:0]  message_word_addr,
    output logic        write_enable_out,
    output logic        start_new_block,
    output logic        last_block,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, LOAD, PAD_ZERO, LEN_HI, LEN_LO, ISSUE, WAIT_CORE} state_t;

    state_t      state, state_d;
    logic [3:0]  addr;
    logic [63:0] bit_len, bit_len_d;
    logic        pad80, pad80_d;       // 0x80 word still owed (last beat was full)
    logic        msg_end, msg_end_d;   // last beat accepted, padding in progress
    logic        len_done, len_done_d; // length written, next issue is the final block
    logic        wr;
    logic [31:0] wr_data;
    logic [2:0]  nbytes_eff;
    logic [31:0] beat_word;
    logic        accept;

    assign accept     = in_valid & in_ready;
    assign nbytes_eff = (!in_last || in_nbytes > 3'd4) ? 3'd4 : in_nbytes;

    // Keep the valid leading bytes and drop the 0x80 marker right behind them.
    always_comb begin
        case (nbytes_eff)
            3'd0:    beat_word = 32'h8000_0000;
            3'd1:    beat_word = {in_data[31:24], 24'h80_0000};
            3'd2:    beat_word = {in_data[31:16], 16'h8000};
            3'd3:    beat_word = {in_data[31:8], 8'h80};
            default: beat_word = in_data;
        endcase
    end

    always_comb begin
        state_d    = state;
        wr         = 1'b0;
        wr_data    = 32'h0;
        pad80_d    = pad80;
        msg_end_d  = msg_end;
        len_done_d = len_done;
        bit_len_d  = bit_len;
        case (state)
            IDLE, LOAD: begin
                if (accept) begin
                    wr        = 1'b1;
                    wr_data   = beat_word;
                    bit_len_d = bit_len + {58'd0, nbytes_eff, 3'd0};
                    if (in_last) begin
                        msg_end_d = 1'b1;
                        if (nbytes_eff == 3'd4) begin
                            pad80_d = 1'b1;
                            state_d = (addr == 4'd15) ? ISSUE : PAD_ZERO;
                        end else if (addr == 4'd13) begin
                            state_d = LEN_HI;
                        end else begin
                            state_d = (addr == 4'd15) ? ISSUE : PAD_ZERO;
                        end
                    end else begin
                        state_d = (addr == 4'd15) ? ISSUE : LOAD;
                    end
                end
            end
            PAD_ZERO: begin
                wr      = 1'b1;
                wr_data = pad80 ? 32'h8000_0000 : 32'h0;
                pad80_d = 1'b0;
                if (addr == 4'd13)      state_d = LEN_HI;
                else if (addr == 4'd15) state_d = ISSUE;
            end
            LEN_HI: begin
                wr      = 1'b1;
                wr_data = bit_len[63:32];
                state_d = LEN_LO;
            end
            LEN_LO: begin
                wr         = 1'b1;
                wr_data    = bit_len[31:0];
                len_done_d = 1'b1;
                state_d    = ISSUE;
            end
            ISSUE: state_d = WAIT_CORE;
            WAIT_CORE: begin
                if (block_done) begin
                    if (len_done) begin
                        state_d    = IDLE;
                        bit_len_d  = 64'd0;
                        msg_end_d  = 1'b0;
                        len_done_d = 1'b0;
                    end else begin
                        state_d = msg_end ? PAD_ZERO : LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            addr              <= 4'd0;
            bit_len           <= 64'd0;
            pad80             <= 1'b0;
            msg_end           <= 1'b0;
            len_done          <= 1'b0;
            in_ready          <= 1'b0;
            write_enable_out  <= 1'b0;
            start_new_block   <= 1'b0;
            last_block        <= 1'b0;
            busy              <= 1'b0;
            message_word_out  <= 32'h0;
            message_word_addr <= 4'd0;
        end else begin
            state            <= state_d;
            bit_len          <= bit_len_d;
            pad80            <= pad80_d;
            msg_end          <= msg_end_d;
            len_done         <= len_done_d;
            write_enable_out <= wr;
            if (wr) begin
                message_word_out  <= wr_data;
                message_word_addr <= addr;
                addr              <= addr + 4'd1;
            end
            in_ready        <= (state_d == IDLE) || (state_d == LOAD);
            start_new_block <= (state_d == ISSUE);
            last_block      <= (state_d == ISSUE) && len_done_d;
            busy            <= (state_d != IDLE);
        end
    end
endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: table of corner-case messages plus random messages,
// every issued block compared against a byte-level SHA-256 padding model.
module tb_sha256_msg_padder;
    logic        clk = 1'b0, reset_n = 1'b1;
    logic        in_valid = 1'b0, in_last = 1'b0, block_done = 1'b0;
    logic [31:0] in_data = 32'h0;
    logic [2:0]  in_nbytes = 3'd0;
    logic        in_ready, write_enable_out, start_new_block, last_block, busy;
    logic [31:0] message_word_out;
    logic [3:0]  message_word_addr;

    sha256_msg_padder dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .in_nbytes(in_nbytes), .block_done(block_done),
        .message_word_out(message_word_out), .message_word_addr(message_word_addr),
        .write_enable_out(write_enable_out), .start_new_block(start_new_block),
        .last_block(last_block), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0, fails = 0;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: standard SHA-256 padding on a byte stream, cut into 16-word blocks.
    logic [31:0] exp_words[$];
    bit          exp_last[$];
    task automatic model_push(input byte unsigned msg[$]);
        byte unsigned p[$];
        longint unsigned bits;
        int nb;
        p = msg;
        bits = 64'(msg.size()) * 8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(8'(bits >> (8 * i)));
        nb = p.size() / 64;
        for (int b = 0; b < nb; b++) begin
            for (int w = 0; w < 16; w++) begin
                int k = 64 * b + 4 * w;
                exp_words.push_back({p[k], p[k+1], p[k+2], p[k+3]});
            end
            exp_last.push_back(b == nb - 1);
        end
    endtask

    // Monitor: capture scheduler writes, compare each issued block with the model.
    logic [31:0] cap [16];
    logic [31:0] last_blk [16];
    logic [15:0] wmask = '0;
    int          nblocks = 0;
    bit          waiting = 0, prev_start = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            wmask = '0;
            waiting = 0;
            prev_start = 0;
        end else begin
            if (waiting) begin
                check("wait_core_quiet", {in_ready, write_enable_out}, 2'b00);
                if (block_done) waiting = 0;
            end
            if (write_enable_out) begin
                cap[message_word_addr] = message_word_out;
                wmask[message_word_addr] = 1'b1;
            end
            if (start_new_block) begin
                check("start_one_cycle", prev_start, 0);
                check("block_all_words", wmask, 16'hFFFF);
                check("block_expected", exp_last.size() != 0, 1);
                if (exp_last.size() != 0) begin
                    for (int w = 0; w < 16; w++)
                        check($sformatf("blk%0d_w%0d", nblocks, w), cap[w], exp_words.pop_front());
                    check($sformatf("blk%0d_last_block", nblocks), last_block, exp_last.pop_front());
                end
                last_blk = cap;
                nblocks++;
                wmask = '0;
                waiting = 1;
            end
            prev_start = start_new_block;
        end
    end

    // Core stand-in: acknowledge each issued block after a random delay; pokes are stray pulses.
    int poke_req = 0, poke_cnt = 0;
    initial forever begin
        @(posedge clk); #1;
        if (reset_n && start_new_block) begin
            repeat (1 + $urandom_range(0, 3)) @(posedge clk);
            #1 block_done = 1'b1;
            @(posedge clk); #1 block_done = 1'b0;
        end else if (poke_req != poke_cnt) begin
            poke_cnt++;
            block_done = 1'b1;
            @(posedge clk); #1 block_done = 1'b0;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic drive_beat(input logic [31:0] d, input logic last, input logic [2:0] nb, input int gap);
        int t = 0;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1; in_data = d; in_last = last; in_nbytes = nb;
        while (!in_ready && t < 200) begin @(posedge clk); #1; t++; end
        if (!in_ready) check("ready_timeout", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = $urandom; in_last = 1'b0; in_nbytes = 3'($urandom);
    endtask

    task automatic send_msg(input byte unsigned msg[$], input bit empty_tail, input int maxgap);
        int pos = 0, t = 0, r;
        logic [31:0] d;
        model_push(msg);
        forever begin
            r = msg.size() - pos;
            if (r > 4 || (r == 4 && empty_tail)) begin
                d = {msg[pos], msg[pos+1], msg[pos+2], msg[pos+3]};
                drive_beat(d, 1'b0, 3'($urandom), $urandom_range(0, maxgap));
                pos += 4;
            end else begin
                d = $urandom;
                for (int i = 0; i < r; i++) d[31 - 8*i -: 8] = msg[pos + i];
                drive_beat(d, 1'b1, 3'(r), $urandom_range(0, maxgap));
                break;
            end
        end
        while ((exp_last.size() != 0 || busy) && t < 3000) begin @(posedge clk); #1; t++; end
        check("msg_complete", {exp_last.size() == 0, busy}, 2'b10);
        check("idle_ready", in_ready, 1);
    endtask

    typedef struct {
        int nfull; int nlast; logic [31:0] ldata;
        int exp_blocks; logic [31:0] w0, w14, w15;
    } vec_t;

    task automatic run_vec(input vec_t v, input string tag);
        byte unsigned msg[$];
        int nb0 = nblocks;
        logic [31:0] ld = v.ldata;
        for (int i = 0; i < v.nfull; i++) begin
            msg.push_back(8'hA5); msg.push_back(8'h00); msg.push_back(8'h00); msg.push_back(8'(i));
        end
        for (int i = 0; i < v.nlast; i++) msg.push_back(ld[31 - 8*i -: 8]);
        send_msg(msg, v.nlast == 0, 2);
        check({tag, "_nblocks"}, nblocks - nb0, v.exp_blocks);
        check({tag, "_w0"}, last_blk[0], v.w0);
        check({tag, "_w14"}, last_blk[14], v.w14);
        check({tag, "_w15"}, last_blk[15], v.w15);
    endtask

    initial begin
        vec_t tbl[9];
        byte unsigned msg[$];
        tbl[0] = '{0,  3, 32'h61626300, 1, 32'h61626380, 32'h0, 32'h18};
        tbl[1] = '{0,  0, 32'hDEADBEEF, 1, 32'h80000000, 32'h0, 32'h0};
        tbl[2] = '{13, 4, 32'h11223344, 2, 32'h0,        32'h0, 32'h1C0};
        tbl[3] = '{15, 4, 32'h55667788, 2, 32'h80000000, 32'h0, 32'h200};
        tbl[4] = '{13, 3, 32'hAABBCCDD, 1, 32'hA5000000, 32'h0, 32'h1B8};
        tbl[5] = '{14, 1, 32'hCAFEF00D, 2, 32'h0,        32'h0, 32'h1C8};
        tbl[6] = '{15, 2, 32'h12345678, 2, 32'h0,        32'h0, 32'h1F0};
        tbl[7] = '{12, 4, 32'h9ABCDEF0, 1, 32'hA5000000, 32'h0, 32'h1A0};
        tbl[8] = '{16, 0, 32'hFFFFFFFF, 2, 32'h80000000, 32'h0, 32'h200};

        #1 reset_n = 1'b0;
        #1 check("reset_outputs", {in_ready, write_enable_out, start_new_block, last_block, busy,
                                   message_word_out, message_word_addr}, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", {in_ready, busy}, 2'b10);

        for (int i = 0; i < 9; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Valid held high across issue/wait; stray block_done while idle/loading.
        msg.delete();
        for (int i = 0; i < 80; i++) msg.push_back(8'($urandom));
        poke_req++;
        send_msg(msg, 1'b0, 0);

        // Reset in the middle of a message, then "abc" must come out unchanged.
        for (int i = 0; i < 5; i++) drive_beat($urandom, 1'b0, 3'd4, 0);
        @(negedge clk); #2 reset_n = 1'b0;
        #1 check("async_reset_outputs", {in_ready, write_enable_out, start_new_block, last_block, busy,
                                         message_word_out, message_word_addr}, 0);
        @(posedge clk); #1;
        check("reset_held_across_edge", {in_ready, write_enable_out, busy}, 0);
        @(posedge clk); #1 reset_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_midreset", in_ready, 1);
        run_vec(tbl[0], "abc_after_reset");

        for (int n = 0; n < 25; n++) begin
            int len = $urandom_range(0, 150);
            msg.delete();
            for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
            send_msg(msg, $urandom_range(0, 1) == 1, 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
